wb_rr_arb3: RTL and testbench

Three-master Wishbone B3 round-robin arbiter that shares one slave port (the on-chip RAM/key-register slave) between the instruction, data and debug masters. It grants whole bus cycles, rotates priority fairly, and enforces a watchdog that terminates hung transfers with an error. It replaces ad-hoc select logic in front of the memory slave.

---
 rtl/wb_arb_pkg.sv | 32 +++
 rtl/rr_pick3.sv | 31 +++
 rtl/wb_rr_arb3.sv | 223 ++++++++++++++++++++++
 tb/tb_wb_rr_arb3.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, constants and rotate helpers for the three-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_MASTERS = 3;
  localparam int WDOG_W_DEF  = 8;

  // Master 0 must win the first arbitration after reset, so "last" starts at master 2.
  localparam logic [NUM_MASTERS-1:0] LAST_RST = 3'b100;

  function automatic logic [1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
    case (oh)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [NUM_MASTERS-1:0] rot3r(input logic [NUM_MASTERS-1:0] v,
                                                   input logic [1:0] n);
    case (n)
      2'd1:    return {v[0], v[2:1]};
      2'd2:    return {v[1:0], v[2]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational rotate-priority picker: first requester after the last winner
module rr_pick3 import wb_arb_pkg::*; (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [NUM_MASTERS-1:0] i_last,
  output logic [NUM_MASTERS-1:0] o_win
);

  logic [1:0]             w_last_idx;
  logic [1:0]             w_start;
  logic [1:0]             w_back;
  logic [NUM_MASTERS-1:0] w_rot;
  logic [NUM_MASTERS-1:0] w_pe;

  // Rotate so bit 0 is the master right after the last winner, take the lowest set bit, rotate back.
  always_comb begin
    w_last_idx = onehot_idx(i_last);
    w_start    = (w_last_idx == 2'd2) ? 2'd0 : w_last_idx + 2'd1;
    w_back     = (w_start == 2'd0) ? 2'd0 : 2'd3 - w_start;
    w_rot      = rot3r(i_req, w_start);
    w_pe       = '0;
    if (w_rot[0]) begin
      w_pe = 3'b001;
    end else if (w_rot[1]) begin
      w_pe = 3'b010;
    end else if (w_rot[2]) begin
      w_pe = 3'b100;
    end
    o_win = rot3r(w_pe, w_back);
  end

endmodule

// File: rtl/wb_rr_arb3.sv
// rtl/wb_rr_arb3.sv - three-master Wishbone B3 round-robin arbiter with a stalled-transfer watchdog
module wb_rr_arb3 import wb_arb_pkg::*; #(
  parameter int dw   = 32,
  parameter int aw   = 32,
  parameter int TO_W = WDOG_W_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic [aw-1:0] wbm0_adr_i,
  input  logic [dw-1:0] wbm0_dat_i,
  input  logic [3:0]    wbm0_sel_i,
  input  logic [2:0]    wbm0_cti_i,
  input  logic [1:0]    wbm0_bte_i,
  input  logic          wbm0_cyc_i,
  input  logic          wbm0_stb_i,
  input  logic          wbm0_we_i,
  output logic [dw-1:0] wbm0_dat_o,
  output logic          wbm0_ack_o,
  output logic          wbm0_err_o,
  output logic          wbm0_rty_o,

  input  logic [aw-1:0] wbm1_adr_i,
  input  logic [dw-1:0] wbm1_dat_i,
  input  logic [3:0]    wbm1_sel_i,
  input  logic [2:0]    wbm1_cti_i,
  input  logic [1:0]    wbm1_bte_i,
  input  logic          wbm1_cyc_i,
  input  logic          wbm1_stb_i,
  input  logic          wbm1_we_i,
  output logic [dw-1:0] wbm1_dat_o,
  output logic          wbm1_ack_o,
  output logic          wbm1_err_o,
  output logic          wbm1_rty_o,

  input  logic [aw-1:0] wbm2_adr_i,
  input  logic [dw-1:0] wbm2_dat_i,
  input  logic [3:0]    wbm2_sel_i,
  input  logic [2:0]    wbm2_cti_i,
  input  logic [1:0]    wbm2_bte_i,
  input  logic          wbm2_cyc_i,
  input  logic          wbm2_stb_i,
  input  logic          wbm2_we_i,
  output logic [dw-1:0] wbm2_dat_o,
  output logic          wbm2_ack_o,
  output logic          wbm2_err_o,
  output logic          wbm2_rty_o,

  output logic [aw-1:0] wbs_adr_o,
  output logic [dw-1:0] wbs_dat_o,
  output logic [3:0]    wbs_sel_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic          wbs_we_o,
  input  logic [dw-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i,

  output logic [NUM_MASTERS-1:0] grant_o,
  output logic          timeout_o
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_last;
  logic [NUM_MASTERS-1:0] w_last_nxt;
  logic [TO_W-1:0]        r_wdog;
  logic [TO_W-1:0]        w_wdog_nxt;

  logic [NUM_MASTERS-1:0] w_cyc;
  logic [NUM_MASTERS-1:0] w_stb;
  logic [NUM_MASTERS-1:0] w_we;
  logic [aw-1:0]          w_adr [NUM_MASTERS];
  logic [dw-1:0]          w_dat [NUM_MASTERS];
  logic [3:0]             w_sel [NUM_MASTERS];
  logic [2:0]             w_cti [NUM_MASTERS];
  logic [1:0]             w_bte [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] w_win;
  logic                   w_cyc_req;
  logic                   w_stb_req;
  logic                   w_term;
  logic                   w_expire;
  logic [aw-1:0]          w_mux_adr;
  logic [dw-1:0]          w_mux_dat;
  logic [3:0]             w_mux_sel;
  logic [2:0]             w_mux_cti;
  logic [1:0]             w_mux_bte;
  logic                   w_mux_we;
  logic [NUM_MASTERS-1:0] w_ack;
  logic [NUM_MASTERS-1:0] w_err;
  logic [NUM_MASTERS-1:0] w_rty;

  assign w_cyc = {wbm2_cyc_i, wbm1_cyc_i, wbm0_cyc_i};
  assign w_stb = {wbm2_stb_i, wbm1_stb_i, wbm0_stb_i};
  assign w_we  = {wbm2_we_i,  wbm1_we_i,  wbm0_we_i};

  assign w_adr[0] = wbm0_adr_i;
  assign w_adr[1] = wbm1_adr_i;
  assign w_adr[2] = wbm2_adr_i;
  assign w_dat[0] = wbm0_dat_i;
  assign w_dat[1] = wbm1_dat_i;
  assign w_dat[2] = wbm2_dat_i;
  assign w_sel[0] = wbm0_sel_i;
  assign w_sel[1] = wbm1_sel_i;
  assign w_sel[2] = wbm2_sel_i;
  assign w_cti[0] = wbm0_cti_i;
  assign w_cti[1] = wbm1_cti_i;
  assign w_cti[2] = wbm2_cti_i;
  assign w_bte[0] = wbm0_bte_i;
  assign w_bte[1] = wbm1_bte_i;
  assign w_bte[2] = wbm2_bte_i;

  rr_pick3 u_pick (
    .i_req  (w_cyc),
    .i_last (r_last),
    .o_win  (w_win)
  );

  // Grant is all-zero in IDLE, so the AND-OR mux also yields the idle-bus zeros.
  always_comb begin
    w_mux_adr = '0;
    w_mux_dat = '0;
    w_mux_sel = '0;
    w_mux_cti = '0;
    w_mux_bte = '0;
    w_mux_we  = 1'b0;
    for (int n = 0; n < NUM_MASTERS; n++) begin
      if (r_grant[n]) begin
        w_mux_adr = w_mux_adr | w_adr[n];
        w_mux_dat = w_mux_dat | w_dat[n];
        w_mux_sel = w_mux_sel | w_sel[n];
        w_mux_cti = w_mux_cti | w_cti[n];
        w_mux_bte = w_mux_bte | w_bte[n];
        w_mux_we  = w_mux_we  | w_we[n];
      end
    end
  end

  assign w_cyc_req = |(r_grant & w_cyc);
  assign w_stb_req = |(r_grant & w_stb);
  assign w_term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A slave termination in the expiry cycle takes precedence over the watchdog.
  assign w_expire  = (r_state == ST_BUSY) && w_stb_req && !w_term && (r_wdog == '1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_cyc) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win;
          w_last_nxt  = w_win;
        end
      end
      ST_BUSY: begin
        if (!w_cyc_req) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else if (w_stb_req && !w_term && !w_expire) begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign wbs_adr_o = w_mux_adr;
  assign wbs_dat_o = w_mux_dat;
  assign wbs_sel_o = w_mux_sel;
  assign wbs_cti_o = w_mux_cti;
  assign wbs_bte_o = w_mux_bte;
  assign wbs_we_o  = w_mux_we;
  assign wbs_cyc_o = w_cyc_req;
  assign wbs_stb_o = w_stb_req & ~w_expire;

  assign w_ack = r_grant & {NUM_MASTERS{wbs_ack_i}};
  assign w_err = r_grant & {NUM_MASTERS{wbs_err_i | w_expire}};
  assign w_rty = r_grant & {NUM_MASTERS{wbs_rty_i}};

  assign wbm0_ack_o = w_ack[0];
  assign wbm1_ack_o = w_ack[1];
  assign wbm2_ack_o = w_ack[2];
  assign wbm0_err_o = w_err[0];
  assign wbm1_err_o = w_err[1];
  assign wbm2_err_o = w_err[2];
  assign wbm0_rty_o = w_rty[0];
  assign wbm1_rty_o = w_rty[1];
  assign wbm2_rty_o = w_rty[2];

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm2_dat_o = wbs_dat_i;

  assign grant_o   = r_grant;
  assign timeout_o = w_expire;

endmodule

// File: tb/tb_wb_rr_arb3.sv
// tb/tb_wb_rr_arb3.sv - scoreboard bench for wb_rr_arb3 with randomized rounds and directed corner cases
module tb_wb_rr_arb3;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [31:0] m_adr [3];
  logic [31:0] m_dat [3];
  logic [3:0]  m_sel [3];
  logic [2:0]  m_cti [3];
  logic [1:0]  m_bte [3];
  logic [2:0]  m_cyc;
  logic [2:0]  m_stb;
  logic [2:0]  m_we;
  wire  [31:0] m_rdat [3];
  wire  [2:0]  m_ack;
  wire  [2:0]  m_err;
  wire  [2:0]  m_rty;

  wire  [31:0] wbs_adr_o;
  wire  [31:0] wbs_dat_o;
  wire  [3:0]  wbs_sel_o;
  wire  [2:0]  wbs_cti_o;
  wire  [1:0]  wbs_bte_o;
  wire         wbs_cyc_o;
  wire         wbs_stb_o;
  wire         wbs_we_o;
  logic [31:0] s_dat;
  logic        s_ack;
  logic        s_err;
  logic        s_rty;
  wire  [2:0]  grant_o;
  wire         timeout_o;

  int          n_vec;
  int          n_bad;
  beat_t       exp_q[$];
  int          mdl_last;

  logic [31:0] jadr [3][4];
  logic [31:0] jdat [3][4];
  logic [2:0]  jcti [3][4];
  logic [3:0]  jsel [3];
  logic        jwe  [3];
  int          jlen [3];
  int          beat [3];
  logic [2:0]  active;

  wb_rr_arb3 dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm0_adr_i (m_adr[0]), .wbm0_dat_i (m_dat[0]), .wbm0_sel_i (m_sel[0]),
    .wbm0_cti_i (m_cti[0]), .wbm0_bte_i (m_bte[0]), .wbm0_cyc_i (m_cyc[0]),
    .wbm0_stb_i (m_stb[0]), .wbm0_we_i  (m_we[0]),  .wbm0_dat_o (m_rdat[0]),
    .wbm0_ack_o (m_ack[0]), .wbm0_err_o (m_err[0]), .wbm0_rty_o (m_rty[0]),
    .wbm1_adr_i (m_adr[1]), .wbm1_dat_i (m_dat[1]), .wbm1_sel_i (m_sel[1]),
    .wbm1_cti_i (m_cti[1]), .wbm1_bte_i (m_bte[1]), .wbm1_cyc_i (m_cyc[1]),
    .wbm1_stb_i (m_stb[1]), .wbm1_we_i  (m_we[1]),  .wbm1_dat_o (m_rdat[1]),
    .wbm1_ack_o (m_ack[1]), .wbm1_err_o (m_err[1]), .wbm1_rty_o (m_rty[1]),
    .wbm2_adr_i (m_adr[2]), .wbm2_dat_i (m_dat[2]), .wbm2_sel_i (m_sel[2]),
    .wbm2_cti_i (m_cti[2]), .wbm2_bte_i (m_bte[2]), .wbm2_cyc_i (m_cyc[2]),
    .wbm2_stb_i (m_stb[2]), .wbm2_we_i  (m_we[2]),  .wbm2_dat_o (m_rdat[2]),
    .wbm2_ack_o (m_ack[2]), .wbm2_err_o (m_err[2]), .wbm2_rty_o (m_rty[2]),
    .wbs_adr_o  (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o),
    .wbs_cti_o  (wbs_cti_o), .wbs_bte_o (wbs_bte_o), .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o), .wbs_we_o  (wbs_we_o),  .wbs_dat_i (s_dat),
    .wbs_ack_i  (s_ack),     .wbs_err_i (s_err),     .wbs_rty_i (s_rty),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int m, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] cti, input logic we);
    beat_t e;
    e.m = m; e.adr = adr; e.dat = dat; e.sel = sel; e.cti = cti; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic set_idle(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_cti[m] = '0; m_bte[m] = '0;
  endtask

  task automatic drive_master(input int m);
    m_adr[m] = jadr[m][beat[m]];
    m_dat[m] = jdat[m][beat[m]];
    m_cti[m] = jcti[m][beat[m]];
    m_sel[m] = jsel[m];
    m_we[m]  = jwe[m];
    m_bte[m] = 2'b00;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
  endtask

  task automatic slave_drive();
    s_ack = wbs_stb_o && ($urandom_range(0, 2) != 0);
    s_dat = $urandom;
  endtask

  // Monitor: checks every slave-acked beat against the scoreboard and the one-dead-cycle rule.
  initial begin
    logic [2:0] prev_g;
    beat_t      e;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (grant_o != prev_g && grant_o != 3'b000) chk("dead_cycle", {29'd0, prev_g}, 32'd0);
        if (wbs_cyc_o && wbs_stb_o && s_ack) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL beat_unexpected: got beat with grant %b expected none", grant_o);
          end else begin
            e = exp_q.pop_front();
            chk("grant", {29'd0, grant_o}, 32'd1 << e.m);
            chk("adr", wbs_adr_o, e.adr);
            chk("sel", {28'd0, wbs_sel_o}, {28'd0, e.sel});
            chk("cti", {29'd0, wbs_cti_o}, {29'd0, e.cti});
            chk("we", {31'd0, wbs_we_o}, {31'd0, e.we});
            if (e.we) chk("wdat", wbs_dat_o, e.dat);
            chk("ack_route", {29'd0, m_ack}, 32'd1 << e.m);
            chk("err_quiet", {29'd0, m_err}, 32'd0);
            chk("rdat", m_rdat[e.m], s_dat);
          end
        end
      end
      prev_g = grant_o;
    end
  end

  // One arbitration round: the masters in mask raise cyc together and keep it until their job ends.
  task automatic run_round(input logic [2:0] mask, input int force_len);
    int         order[3];
    int         n;
    int         budget;
    bit         first;
    logic [2:0] ack_seen;
    logic [31:0] base;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (mdl_last + k) % 3;
      if (mask[idx]) begin
        order[n] = idx;
        n++;
      end
    end
    for (int m = 0; m < 3; m++) begin
      if (mask[m]) begin
        jlen[m] = (force_len > 0) ? force_len : int'($urandom_range(1, 4));
        jwe[m]  = 1'($urandom_range(0, 1));
        jsel[m] = 4'($urandom_range(1, 15));
        base    = $urandom & 32'hFFFF_FFF0;
        for (int b = 0; b < jlen[m]; b++) begin
          jadr[m][b] = base + 32'(4 * b);
          jdat[m][b] = $urandom;
          jcti[m][b] = (jlen[m] == 1) ? 3'b000 : ((b == jlen[m] - 1) ? 3'b111 : 3'b010);
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < jlen[order[i]]; b++) begin
        push_exp(order[i], jadr[order[i]][b], jdat[order[i]][b], jsel[order[i]],
                 jcti[order[i]][b], jwe[order[i]]);
      end
    end
    mdl_last = order[n-1];

    @(posedge clk); #1;
    for (int m = 0; m < 3; m++) begin
      if (mask[m]) begin
        beat[m] = 0;
        active[m] = 1'b1;
        drive_master(m);
      end
    end
    s_ack = 1'b0;
    @(negedge clk);
    chk("grant_pre", {29'd0, grant_o}, 32'd0);
    @(posedge clk); #2;
    slave_drive();
    first = 1'b1;
    budget = 0;
    while (active != 3'b000 && budget < 400) begin
      @(negedge clk);
      if (first) chk("grant_latency", {29'd0, grant_o}, 32'd1 << order[0]);
      first = 1'b0;
      ack_seen = m_ack;
      @(posedge clk); #1;
      for (int m = 0; m < 3; m++) begin
        if (active[m] && ack_seen[m]) begin
          beat[m]++;
          if (beat[m] == jlen[m]) begin
            set_idle(m);
            active[m] = 1'b0;
          end else begin
            drive_master(m);
          end
        end
      end
      #1;
      slave_drive();
      budget++;
    end
    if (active != 3'b000) begin
      n_vec++;
      n_bad++;
      $display("FAIL round_timeout: got active=%b expected 000 within 400 cycles", active);
      for (int m = 0; m < 3; m++) set_idle(m);
      active = '0;
      exp_q.delete();
    end
    s_ack = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Master 1 stalls with no slave response; optionally the slave acks in the expiry cycle.
  task automatic wd_test(input bit ack_at_end);
    bit early;
    @(posedge clk); #1;
    m_adr[1] = ack_at_end ? 32'h200 : 32'h100;
    m_sel[1] = 4'hF; m_we[1] = 1'b0; m_cti[1] = 3'b000; m_bte[1] = 2'b00;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    s_ack = 1'b0;
    s_dat = 32'hA5A5_0F0F;
    mdl_last = 1;
    if (ack_at_end) push_exp(1, 32'h200, 32'h0, 4'hF, 3'b000, 1'b0);
    @(posedge clk);
    early = 1'b0;
    repeat (255) begin
      @(negedge clk);
      if (m_err != 3'b000 || timeout_o || !wbs_stb_o) early = 1'b1;
      @(posedge clk);
    end
    chk(ack_at_end ? "wdog_early_a" : "wdog_early", {31'd0, early}, 32'd0);
    if (ack_at_end) begin
      #1 s_ack = 1'b1;
      @(negedge clk);
      chk("late_ack", {29'd0, m_ack}, 32'h2);
      chk("late_ack_err", {29'd0, m_err}, 32'd0);
      chk("late_ack_tmo", {31'd0, timeout_o}, 32'd0);
      chk("late_ack_stb", {31'd0, wbs_stb_o}, 32'd1);
      @(posedge clk); #1;
      s_ack = 1'b0;
    end else begin
      @(negedge clk);
      chk("wdog_err", {29'd0, m_err}, 32'h2);
      chk("wdog_tmo", {31'd0, timeout_o}, 32'd1);
      chk("wdog_stb", {31'd0, wbs_stb_o}, 32'd0);
      chk("wdog_cyc", {31'd0, wbs_cyc_o}, 32'd1);
      chk("wdog_ack", {29'd0, m_ack}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("wdog_clear_tmo", {31'd0, timeout_o}, 32'd0);
      chk("wdog_clear_stb", {31'd0, wbs_stb_o}, 32'd1);
      @(posedge clk); #1;
    end
    set_idle(1);
    repeat (2) @(posedge clk);
  endtask

  // Master 2 runs two beats of a write burst, then reset lands mid-cycle.
  task automatic rst_test();
    logic [31:0] base;
    logic [31:0] d0;
    logic [31:0] d1;
    base = 32'h0000_4000;
    d0 = $urandom;
    d1 = $urandom;
    @(posedge clk); #1;
    m_adr[2] = base; m_dat[2] = d0; m_sel[2] = 4'hF; m_we[2] = 1'b1;
    m_cti[2] = 3'b010; m_bte[2] = 2'b00; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    push_exp(2, base, d0, 4'hF, 3'b010, 1'b1);
    push_exp(2, base + 32'd4, d1, 4'hF, 3'b010, 1'b1);
    @(posedge clk); #1;
    s_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    m_adr[2] = base + 32'd4; m_dat[2] = d1;
    @(negedge clk);
    @(posedge clk); #1;
    m_adr[2] = base + 32'd8;
    s_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_cyc", {31'd0, wbs_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wbs_stb_o}, 32'd0);
    chk("rst_grant", {29'd0, grant_o}, 32'd0);
    chk("rst_ack", {29'd0, m_ack}, 32'd0);
    chk("burst_beats", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    set_idle(2);
    @(negedge clk);
    rst = 1'b0;
    mdl_last = 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1 ms");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    mdl_last = 2;
    active = '0;
    rst = 1'b1;
    for (int m = 0; m < 3; m++) set_idle(m);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    repeat (2) @(negedge clk);
    chk("reset_grant", {29'd0, grant_o}, 32'd0);
    chk("reset_cyc", {31'd0, wbs_cyc_o}, 32'd0);
    chk("reset_stb", {31'd0, wbs_stb_o}, 32'd0);
    chk("reset_adr", wbs_adr_o, 32'd0);
    chk("reset_tmo", {31'd0, timeout_o}, 32'd0);
    chk("reset_ack", {29'd0, m_ack}, 32'd0);
    chk("reset_err", {29'd0, m_err}, 32'd0);
    rst = 1'b0;

    run_round(3'b111, 1);
    run_round(3'b010, 1);
    run_round(3'b101, 4);
    for (int i = 0; i < 20; i++) run_round(3'($urandom_range(1, 7)), 0);
    wd_test(1'b0);
    wd_test(1'b1);
    rst_test();
    run_round(3'b111, 4);
    for (int i = 0; i < 5; i++) run_round(3'($urandom_range(1, 7)), 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
